// File: rtl/mnist_img_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mnist_img_pkg
// Description : Shared geometry and state encoding for the MNIST frame sampler.
// Revision    : 1.0 - initial release
// ============================================================================
package mnist_img_pkg;

    localparam int H_TOTAL    = 640;
    localparam int V_TOTAL    = 480;
    localparam int H_START    = 96;
    localparam int V_START    = 16;
    localparam int STEP       = 16;
    localparam int OUT_DIM    = 28;
    localparam int IMG_PIXELS = OUT_DIM * OUT_DIM;
    localparam int ADDR_W     = 10;
    localparam int CNT_W      = 10;
    localparam int PH_W       = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } sampler_state_t;

endpackage
`default_nettype wire

// File: rtl/raster_tracker.sv
`default_nettype none
// ============================================================================
// Module      : raster_tracker
// Description : Raster h/v counters with tile phase counters; flags window,
//               tile-origin and final-sample positions of the current pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module raster_tracker
    import mnist_img_pkg::*;
#(
    parameter int FRAME_W = H_TOTAL,
    parameter int FRAME_H = V_TOTAL,
    parameter int CROP_X  = H_START,
    parameter int CROP_Y  = V_START,
    parameter int TILE    = STEP,
    parameter int GRID    = OUT_DIM
) (
    input  logic clk,
    input  logic reset,
    input  logic i_restart,
    input  logic i_step,
    output logic o_in_window,
    output logic o_sample_hit,
    output logic o_last_pixel
);

    localparam logic [CNT_W-1:0] c_H_LO   = CNT_W'(CROP_X);
    localparam logic [CNT_W-1:0] c_H_HI   = CNT_W'(CROP_X + GRID * TILE - 1);
    localparam logic [CNT_W-1:0] c_V_LO   = CNT_W'(CROP_Y);
    localparam logic [CNT_W-1:0] c_V_HI   = CNT_W'(CROP_Y + GRID * TILE - 1);
    localparam logic [CNT_W-1:0] c_H_MAX  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] c_V_MAX  = CNT_W'(FRAME_H - 1);
    localparam logic [CNT_W-1:0] c_H_LAST = CNT_W'(CROP_X + (GRID - 1) * TILE);
    localparam logic [CNT_W-1:0] c_V_LAST = CNT_W'(CROP_Y + (GRID - 1) * TILE);
    // Phase at position 0 is chosen so the phase reads zero on every crop-aligned tile origin.
    localparam logic [PH_W-1:0]  c_H_PH0  = PH_W'((TILE - (CROP_X % TILE)) % TILE);
    localparam logic [PH_W-1:0]  c_V_PH0  = PH_W'((TILE - (CROP_Y % TILE)) % TILE);
    localparam logic [PH_W-1:0]  c_PH_MAX = PH_W'(TILE - 1);

    logic [CNT_W-1:0] r_h, r_v;
    logic [PH_W-1:0]  r_hph, r_vph;
    logic [CNT_W-1:0] w_h, w_v;
    logic [PH_W-1:0]  w_hph, w_vph;

    // A restart pixel is treated as (0,0) in the cycle it arrives.
    always_comb begin
        w_h   = i_restart ? '0      : r_h;
        w_v   = i_restart ? '0      : r_v;
        w_hph = i_restart ? c_H_PH0 : r_hph;
        w_vph = i_restart ? c_V_PH0 : r_vph;
        o_in_window  = (w_h >= c_H_LO) && (w_h <= c_H_HI) &&
                       (w_v >= c_V_LO) && (w_v <= c_V_HI);
        o_sample_hit = (w_hph == '0) && (w_vph == '0);
        o_last_pixel = o_in_window && o_sample_hit &&
                       (w_h == c_H_LAST) && (w_v == c_V_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h   <= '0;
            r_v   <= '0;
            r_hph <= c_H_PH0;
            r_vph <= c_V_PH0;
        end else if (i_step) begin
            if (w_h == c_H_MAX) begin
                r_h   <= '0;
                r_hph <= c_H_PH0;
                if (w_v == c_V_MAX) begin
                    r_v   <= '0;
                    r_vph <= c_V_PH0;
                end else begin
                    r_v   <= w_v + CNT_W'(1);
                    r_vph <= (w_vph == c_PH_MAX) ? '0 : w_vph + PH_W'(1);
                end
            end else begin
                r_h   <= w_h + CNT_W'(1);
                r_hph <= (w_hph == c_PH_MAX) ? '0 : w_hph + PH_W'(1);
                r_v   <= w_v;
                r_vph <= w_vph;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mnist_frame_sampler.sv
`default_nettype none
// ============================================================================
// Module      : mnist_frame_sampler
// Description : Captures one down-sampled BW frame into the NN image buffer
//               and holds it until the network acknowledges it.
// Revision    : 1.0 - initial release
// ============================================================================
module mnist_frame_sampler
    import mnist_img_pkg::*;
#(
    parameter int FRAME_W = H_TOTAL,
    parameter int FRAME_H = V_TOTAL,
    parameter int CROP_X  = H_START,
    parameter int CROP_Y  = V_START,
    parameter int TILE    = STEP,
    parameter int GRID    = OUT_DIM
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              sof,
    input  logic              pix_valid,
    input  logic [7:0]        bw_pixel,
    input  logic              nn_ack,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data,
    output logic              busy,
    output logic              frame_ready
);

    sampler_state_t    r_state, w_state_nxt;
    logic              r_wr_en, r_wr_data, r_last;
    logic [ADDR_W-1:0] r_wr_addr, r_addr_cnt, w_addr_base;
    logic              w_pix_sof, w_done_now, w_restart, w_step, w_hit;
    logic              w_in_window, w_sample_hit, w_last_pixel;

    raster_tracker #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .CROP_X  (CROP_X),
        .CROP_Y  (CROP_Y),
        .TILE    (TILE),
        .GRID    (GRID)
    ) u_raster_tracker (
        .clk          (clk),
        .reset        (reset),
        .i_restart    (w_restart),
        .i_step       (w_step),
        .o_in_window  (w_in_window),
        .o_sample_hit (w_sample_hit),
        .o_last_pixel (w_last_pixel)
    );

    // The final write is in flight this cycle; the rest of the frame is dropped.
    assign w_pix_sof   = sof & pix_valid;
    assign w_done_now  = (r_state == CAPTURE) & r_wr_en & r_last;
    assign w_restart   = w_pix_sof & ((r_state == WAIT_SOF) |
                                      ((r_state == CAPTURE) & ~w_done_now));
    assign w_step      = w_restart | (pix_valid & (r_state == CAPTURE) & ~w_done_now);
    assign w_hit       = w_step & w_in_window & w_sample_hit;
    assign w_addr_base = w_restart ? '0 : r_addr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        frame_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (capture) w_state_nxt = WAIT_SOF;
            end
            WAIT_SOF: begin
                busy = 1'b1;
                if (w_pix_sof) w_state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy = 1'b1;
                if (w_done_now) w_state_nxt = DONE;
            end
            DONE: begin
                frame_ready = 1'b1;
                if (nn_ack) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 1'b0;
            r_addr_cnt <= '0;
            r_last     <= 1'b0;
        end else begin
            r_wr_en <= w_hit;
            r_last  <= w_hit & w_last_pixel;
            if (w_hit) begin
                r_wr_addr  <= w_addr_base;
                r_wr_data  <= (bw_pixel == 8'hFF);
                r_addr_cnt <= w_addr_base + ADDR_W'(1);
            end else if (w_restart) begin
                r_addr_cnt <= '0;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mnist_frame_sampler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mnist_frame_sampler
// Description : Randomised self-checking bench on a reduced raster geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mnist_frame_sampler;

    localparam int FW   = 64;
    localparam int FH   = 40;
    localparam int CX   = 10;
    localparam int CY   = 5;
    localparam int TL   = 4;
    localparam int GD   = 7;
    localparam int NPIX = GD * GD;

    logic       clk = 1'b0;
    logic       reset, capture, sof, pix_valid, nn_ack;
    logic [7:0] bw_pixel;
    logic       wr_en, wr_data, busy, frame_ready;
    logic [9:0] wr_addr;

    int     n_checks = 0;
    int     n_errors = 0;
    logic [7:0] pix   [FH][FW];
    longint     pix_t [FH][FW];
    int     got_addr[$];
    int     got_data[$];
    longint got_t[$];
    logic   fr_prev   = 1'b0;
    longint fr_rise_t = 0;

    mnist_frame_sampler #(
        .FRAME_W (FW),
        .FRAME_H (FH),
        .CROP_X  (CX),
        .CROP_Y  (CY),
        .TILE    (TL),
        .GRID    (GD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .capture     (capture),
        .sof         (sof),
        .pix_valid   (pix_valid),
        .bw_pixel    (bw_pixel),
        .nn_ack      (nn_ack),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_ready (frame_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            got_addr.push_back(int'(wr_addr));
            got_data.push_back(int'(wr_data));
            got_t.push_back($time);
        end
        if (frame_ready && !fr_prev) fr_rise_t = $time;
        fr_prev = frame_ready;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        got_addr.delete();
        got_data.delete();
        got_t.delete();
    endtask

    // single=1 makes only the pixel at tile (row 1, col 1) white.
    task automatic drive_frame(input int lines, input int gap_pct, input bit single);
        for (int v = 0; v < lines; v++) begin
            for (int h = 0; h < FW; h++) begin
                while (int'($urandom_range(99)) < gap_pct) begin
                    @(negedge clk);
                    pix_valid = 1'b0;
                    sof       = 1'b0;
                    bw_pixel  = 8'($urandom);
                end
                @(negedge clk);
                pix_valid = 1'b1;
                sof       = (h == 0) && (v == 0);
                if (single) bw_pixel = (h == CX + TL && v == CY + TL) ? 8'hFF : 8'h00;
                else        bw_pixel = ($urandom_range(1) == 1) ? 8'hFF : 8'h00;
                pix[v][h]   = bw_pixel;
                pix_t[v][h] = $time;
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Reference: grid cell (r,c) comes from raster pixel (CX+c*TL, CY+r*TL), one clock later.
    task automatic compare_frame(input string tag);
        int x, y;
        check({tag, "_count"}, got_addr.size(), NPIX);
        for (int i = 0; i < NPIX && i < got_addr.size(); i++) begin
            x = CX + (i % GD) * TL;
            y = CY + (i / GD) * TL;
            check({tag, "_addr"}, got_addr[i], i);
            check({tag, "_data"}, got_data[i], (pix[y][x] == 8'hFF) ? 1 : 0);
            check({tag, "_lat"}, got_t[i] - pix_t[y][x], 10);
        end
        if (got_t.size() > 0)
            check({tag, "_ready_lat"}, fr_rise_t - got_t[got_t.size() - 1], 10);
        check({tag, "_ready"}, frame_ready, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic start_capture();
        @(negedge clk);
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        check("capture_busy", busy, 1);
    endtask

    task automatic ack_frame();
        @(negedge clk);
        check("ack_hold", frame_ready, 1);
        nn_ack = 1'b1;
        @(negedge clk);
        nn_ack = 1'b0;
        check("ack_ready", frame_ready, 0);
        check("ack_busy", busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        capture   = 1'b0;
        sof       = 1'b0;
        pix_valid = 1'b0;
        nn_ack    = 1'b0;
        bw_pixel  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", frame_ready, 0);
        reset = 1'b0;

        // Full gap-free frame with random BW data
        start_capture();
        clear_q();
        drive_frame(FH, 0, 1'b0);
        compare_frame("full");

        // DONE holds: pixels and sof ignored, no writes while ack is low
        clear_q();
        drive_frame(15, 0, 1'b0);
        check("done_no_writes", got_addr.size(), 0);
        check("done_ready", frame_ready, 1);
        repeat (40) @(negedge clk);
        ack_frame();

        // Single white pixel at tile (1,1)
        start_capture();
        clear_q();
        drive_frame(FH, 0, 1'b1);
        compare_frame("white");

        // Ack and capture together: ack first, capture honoured in IDLE
        @(negedge clk);
        check("combo_hold", frame_ready, 1);
        capture = 1'b1;
        nn_ack  = 1'b1;
        @(negedge clk);
        nn_ack = 1'b0;
        check("combo_ready", frame_ready, 0);
        check("combo_idle", busy, 0);
        @(negedge clk);
        capture = 1'b0;
        check("combo_armed", busy, 1);

        // Random pix_valid gaps
        clear_q();
        drive_frame(FH, 30, 1'b0);
        compare_frame("gaps");
        ack_frame();

        // Mid-frame sof aborts the partial frame and restarts at address 0
        start_capture();
        clear_q();
        drive_frame(20, 0, 1'b0);
        check("abort_partial", got_addr.size(), 4 * GD);
        check("abort_ready", frame_ready, 0);
        check("abort_busy", busy, 1);
        clear_q();
        drive_frame(FH, 10, 1'b0);
        compare_frame("restart");
        ack_frame();

        // Reset in the middle of a capture
        start_capture();
        clear_q();
        drive_frame(CY + 3 * TL, 0, 1'b0);
        check("midrst_count", got_addr.size(), 3 * GD);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_wr_en", wr_en, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", frame_ready, 0);
        clear_q();
        drive_frame(FH, 0, 1'b0);
        check("idle_no_writes", got_addr.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_ready", frame_ready, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
